// File: rtl/ram_responder.sv
// 256 x 8 backing-store responder with req/ack handshake and programmable access latency.
// Define RAM_POSTED_WRITE_EN to add a one-entry posted-write buffer that acks writes early.
module ram_responder #(
    parameter int LATENCY   = 4,
    parameter int INIT_FILL = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req,
    input  logic       wren,
    input  logic [7:0] address,
    input  logic [7:0] data,
    output logic [7:0] q,
    output logic       ready,
    output logic       ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [255:0][7:0] mem_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < 256; i++) begin
            m[8'(i)] = (INIT_FILL != 0) ? 8'(i) : 8'h00;
        end
        return m;
    endfunction

    // Contents are established at time zero only; reset never touches the array.
    mem_t mem = init_mem();

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       accept;
    logic       complete;
    logic       wr_block;
    logic       post_wr;
    logic       wren_p0;
    logic [7:0] addr_p0;
    logic [7:0] rd_data;

`ifdef RAM_POSTED_WRITE_EN
    logic       pb_valid;
    logic [7:0] pb_addr;
    logic [7:0] pb_data;
    logic [3:0] pb_cnt;
    logic       pb_drain;

    // A second write must wait for the buffer to drain; reads pass straight through.
    assign wr_block = req && wren && pb_valid;
    assign post_wr  = wren;
    assign pb_drain = pb_valid && (pb_cnt == 4'd0);
    assign rd_data  = (pb_valid && (pb_addr == addr_p0)) ? pb_data : mem[addr_p0];
`else
    logic [7:0] data_p0;

    assign wr_block = 1'b0;
    assign post_wr  = 1'b0;
    assign rd_data  = mem[addr_p0];
`endif

    assign accept   = (state == S_IDLE) && req && !wr_block;
    assign complete = (state == S_WAIT) && (cnt == 4'd0);

    // ---- stage: FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = post_wr ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        ack   = 1'b0;
        case (state)
            S_IDLE:  ready = !wr_block;
            S_DONE:  ack   = 1'b1;
            default: begin
                ready = 1'b0;
                ack   = 1'b0;
            end
        endcase
    end

    // ---- stage: latency counter and read-data register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= 8'h00;
        end else if (complete && !wren_p0) begin
            q <= rd_data;
        end
    end

    // ---- stage: request capture (data path, not reset)
    always_ff @(posedge clock) begin
        if (accept) begin
            wren_p0 <= wren;
            addr_p0 <= address;
        end
    end

`ifdef RAM_POSTED_WRITE_EN
    // ---- stage: posted-write buffer control
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pb_valid <= 1'b0;
            pb_cnt   <= 4'd0;
        end else if (accept && wren) begin
            pb_valid <= 1'b1;
            pb_cnt   <= CNT_LOAD;
        end else if (pb_drain) begin
            pb_valid <= 1'b0;
        end else if (pb_valid) begin
            pb_cnt   <= pb_cnt - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && wren) begin
            pb_addr <= address;
            pb_data <= data;
        end
    end

    // ---- stage: array write from the drained buffer
    always_ff @(posedge clock) begin
        if (pb_drain) begin
            mem[pb_addr] <= pb_data;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (accept) begin
            data_p0 <= data;
        end
    end

    // ---- stage: array write at the end of the latency window
    always_ff @(posedge clock) begin
        if (complete && wren_p0) begin
            mem[addr_p0] <= data_p0;
        end
    end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed and randomized bench for ram_responder; one instance at LATENCY=4, one at LATENCY=1.
module tb_ram_responder;

    localparam int LAT4 = 4;
    localparam int LAT1 = 1;
`ifdef RAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_s   [2];
    logic       wren_s  [2];
    logic [7:0] addr_s  [2];
    logic [7:0] data_s  [2];
    logic [7:0] q_s     [2];
    logic       ready_s [2];
    logic       ack_s   [2];

    int errors = 0;
    int checks = 0;

    // Reference: array contents and the value q should be holding, per instance.
    logic [7:0] mm [2][256];
    logic [7:0] mq [2];

    always #5 clock = ~clock;

    ram_responder #(.LATENCY(LAT4), .INIT_FILL(1)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_s[0]),
        .wren    (wren_s[0]),
        .address (addr_s[0]),
        .data    (data_s[0]),
        .q       (q_s[0]),
        .ready   (ready_s[0]),
        .ack     (ack_s[0])
    );

    ram_responder #(.LATENCY(LAT1), .INIT_FILL(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_s[1]),
        .wren    (wren_s[1]),
        .address (addr_s[1]),
        .data    (data_s[1]),
        .q       (q_s[1]),
        .ready   (ready_s[1]),
        .ack     (ack_s[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input int s, input bit eack, input bit erdy, input string tag);
        chk({tag, ".ack"},   {7'd0, ack_s[s]},   {7'd0, eack});
        chk({tag, ".ready"}, {7'd0, ready_s[s]}, {7'd0, erdy});
        chk({tag, ".q"},     q_s[s],             mq[s]);
    endtask

    // One isolated transaction; checks every cycle from the accept edge until idle again.
    task automatic txn(input int s, input bit wr, input logic [7:0] a, input logic [7:0] d);
        int    lat;
        bit    early;
        string tag;
        lat   = (s == 1) ? LAT1 : LAT4;
        early = POSTED && wr;
        tag   = wr ? "wr" : "rd";
        @(negedge clock);
        chk({tag, ".pre_ready"}, {7'd0, ready_s[s]}, 8'd1);
        req_s[s]  = 1'b1;
        wren_s[s] = wr;
        addr_s[s] = a;
        data_s[s] = d;
        @(negedge clock);
        req_s[s] = 1'b0;
        for (int c = 0; c <= lat + 1; c++) begin
            if (c > 0) @(negedge clock);
            if (early) begin
                check_out(s, c == 0, c >= 1, tag);
            end else begin
                if ((c == lat) && !wr) mq[s] = mm[s][a];
                check_out(s, c == lat, c == lat + 1, tag);
            end
        end
        if (wr) mm[s][a] = d;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation did not finish in time");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_s[s]  = 1'b0;
            wren_s[s] = 1'b0;
            addr_s[s] = 8'h00;
            data_s[s] = 8'h00;
            mq[s]     = 8'h00;
            for (int i = 0; i < 256; i++) mm[s][i] = 8'(i);
        end

        // Reset state
        reset_n = 1'b0;
        @(negedge clock);
        check_out(0, 1'b0, 1'b1, "reset4");
        check_out(1, 1'b0, 1'b1, "reset1");
        reset_n = 1'b1;

        // Basic read, then write/readback
        txn(0, 1'b0, 8'h3C, 8'h00);
        chk("t1.q", q_s[0], 8'h3C);
        txn(0, 1'b1, 8'h10, 8'hA5);
        chk("t2.q_after_wr", q_s[0], 8'h3C);
        txn(0, 1'b0, 8'h10, 8'h00);
        chk("t2.q10", q_s[0], 8'hA5);
        txn(0, 1'b0, 8'h11, 8'h00);
        chk("t2.q11", q_s[0], 8'h11);

        // req held through ack starts a second transaction from IDLE
        @(negedge clock);
        req_s[0]  = 1'b1;
        wren_s[0] = 1'b0;
        addr_s[0] = 8'h22;
        @(negedge clock);
        for (int c = 0; c <= 2 * LAT4 + 3; c++) begin
            if (c > 0) @(negedge clock);
            if (c == LAT4)         mq[0] = mm[0][8'h22];
            if (c == 2 * LAT4 + 2) mq[0] = mm[0][8'h23];
            check_out(0, (c == LAT4) || (c == 2 * LAT4 + 2),
                      (c == LAT4 + 1) || (c == 2 * LAT4 + 3), "hold");
            if (c == LAT4 + 1)     addr_s[0] = 8'h23;
            if (c == 2 * LAT4 + 2) req_s[0]  = 1'b0;
        end

        // A write request pulsed while busy is ignored
        @(negedge clock);
        req_s[0]  = 1'b1;
        wren_s[0] = 1'b0;
        addr_s[0] = 8'h30;
        @(negedge clock);
        for (int c = 0; c <= LAT4 + 6; c++) begin
            if (c > 0) @(negedge clock);
            if (c == LAT4) mq[0] = mm[0][8'h30];
            check_out(0, c == LAT4, c >= LAT4 + 1, "pulse");
            if (c == 0) begin
                wren_s[0] = 1'b1;
                addr_s[0] = 8'h31;
                data_s[0] = 8'hEE;
            end
            if (c == 2) begin
                req_s[0]  = 1'b0;
                wren_s[0] = 1'b0;
            end
        end
        txn(0, 1'b0, 8'h31, 8'h00);
        chk("pulse.q31", q_s[0], 8'h31);

        // Reset in the middle of a write drops it
        @(negedge clock);
        req_s[0]  = 1'b1;
        wren_s[0] = 1'b1;
        addr_s[0] = 8'h20;
        data_s[0] = 8'h77;
        @(negedge clock);
        req_s[0] = 1'b0;
        for (int c = 0; c <= 2; c++) begin
            if (c > 0) @(negedge clock);
            chk("rstmid.ack_pre", {7'd0, ack_s[0]}, {7'd0, POSTED && (c == 0)});
        end
        #2 reset_n = 1'b0;
        #1;
        mq[0] = 8'h00;
        mq[1] = 8'h00;
        check_out(0, 1'b0, 1'b1, "rstmid4");
        check_out(1, 1'b0, 1'b1, "rstmid1");
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check_out(0, 1'b0, 1'b1, "rstpost");
        end
        txn(0, 1'b0, 8'h20, 8'h00);
        chk("rstmid.q20", q_s[0], 8'h20);

        // LATENCY=1: single read, then back-to-back reads every 3 cycles
        txn(1, 1'b0, 8'h05, 8'h00);
        chk("lat1.q05", q_s[1], 8'h05);
        @(negedge clock);
        req_s[1]  = 1'b1;
        wren_s[1] = 1'b0;
        addr_s[1] = 8'h06;
        @(negedge clock);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clock);
            if ((c % 3) == 1) mq[1] = mm[1][addr_s[1]];
            check_out(1, (c % 3) == 1, (c % 3) == 2, "b2b");
            if ((c % 3) == 2) begin
                if (c < 8) addr_s[1] = addr_s[1] + 8'd1;
                else       req_s[1]  = 1'b0;
            end
        end
        chk("b2b.q08", q_s[1], 8'h08);

        // Address boundaries
        txn(0, 1'b1, 8'hFF, 8'h5C);
        txn(0, 1'b0, 8'hFF, 8'h00);
        chk("edge.qFF", q_s[0], 8'h5C);
        txn(0, 1'b0, 8'h00, 8'h00);
        chk("edge.q00", q_s[0], 8'h00);

        // Randomized mix against the reference model
        for (int n = 0; n < 24; n++) begin
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
        end

`ifdef RAM_POSTED_WRITE_EN
        // Early write ack followed by an immediate read of the same address
        @(negedge clock);
        req_s[0]  = 1'b1;
        wren_s[0] = 1'b1;
        addr_s[0] = 8'h40;
        data_s[0] = 8'h5A;
        @(negedge clock);
        check_out(0, 1'b1, 1'b0, "pw.ack");
        wren_s[0] = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            if (c == 6) mq[0] = 8'h5A;
            check_out(0, c == 6, (c == 1) || (c == 7), "pw.rd");
            if (c == 2) req_s[0] = 1'b0;
        end
        mm[0][8'h40] = 8'h5A;
        chk("pw.q40", q_s[0], 8'h5A);

        // Second write stalls until the buffer drains
        @(negedge clock);
        req_s[0]  = 1'b1;
        wren_s[0] = 1'b1;
        addr_s[0] = 8'h41;
        data_s[0] = 8'hC3;
        @(negedge clock);
        check_out(0, 1'b1, 1'b0, "pw.w1");
        addr_s[0] = 8'h42;
        data_s[0] = 8'h3D;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            check_out(0, c == 5, (c == 4) || (c == 6), "pw.stall");
            if (c == 5) begin
                req_s[0]  = 1'b0;
                wren_s[0] = 1'b0;
            end
        end
        mm[0][8'h41] = 8'hC3;
        mm[0][8'h42] = 8'h3D;
        txn(0, 1'b0, 8'h41, 8'h00);
        chk("pw.q41", q_s[0], 8'hC3);
        txn(0, 1'b0, 8'h42, 8'h00);
        chk("pw.q42", q_s[0], 8'h3D);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
